// File: rtl/stopwatch_time_fmt_if.sv
// Bus between the stopwatch counter/display stage and the time formatter.
interface stopwatch_time_fmt_if;
    logic [31:0] count_in;
    logic        conv_req;
    logic        busy;
    logic        valid;
    logic [3:0]  min_tens;
    logic [3:0]  min_ones;
    logic [3:0]  sec_tens;
    logic [3:0]  sec_ones;
    logic [3:0]  cs_tens;
    logic [3:0]  cs_ones;
    logic        overflow;

    modport master (
        output count_in, conv_req,
        input  busy, valid, min_tens, min_ones, sec_tens, sec_ones,
               cs_tens, cs_ones, overflow
    );

    modport slave (
        input  count_in, conv_req,
        output busy, valid, min_tens, min_ones, sec_tens, sec_ones,
               cs_tens, cs_ones, overflow
    );
endinterface

// File: rtl/stopwatch_time_fmt.sv
// Tick count to MM:SS.cc BCD formatter. Six back-to-back restoring divisions
// (32 cycles each) share one divider; digits are committed all at once.
module stopwatch_time_fmt #(
    parameter logic [31:0] TICKS_PER_CS = 32'd1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    stopwatch_time_fmt_if.slave  bus
);
    typedef enum logic {S_IDLE, S_DIV} state_t;

    state_t      r_state, w_state_nxt;
    logic [2:0]  r_k;
    logic [4:0]  r_bit;
    logic [31:0] r_dvd;
    logic [31:0] r_quo;
    logic [32:0] r_rem;
    logic [31:0] r_min, r_sec, r_cs;
    logic [3:0]  r_mt, r_mo, r_st, r_so;
    logic [3:0]  r_o_mt, r_o_mo, r_o_st, r_o_so, r_o_ct, r_o_co;
    logic        r_o_ovf, r_valid;

    logic [31:0] w_dvsr;
    logic [32:0] w_shift, w_rem_nxt;
    logic [31:0] w_quo_nxt;
    logic        w_ge, w_accept, w_done, w_busy;
    logic        w_unused;

    assign w_accept = (r_state == S_IDLE) && bus.conv_req;
    assign w_done   = (r_state == S_DIV) && (r_bit == 5'd0) && (r_k == 3'd5);
    // remainder is always < divisor, so the top bit never carries into the shift
    assign w_unused = r_rem[32];

    // divisor for the current division step
    always_comb begin
        w_dvsr = 32'd10;
        case (r_k)
            3'd0:    w_dvsr = TICKS_PER_CS;
            3'd1:    w_dvsr = 32'd6000;
            3'd2:    w_dvsr = 32'd100;
            default: w_dvsr = 32'd10;
        endcase
    end

    // one restoring-division step: shift in next dividend bit, trial subtract
    always_comb begin
        w_shift   = {r_rem[31:0], r_dvd[r_bit]};
        w_ge      = (w_shift >= {1'b0, w_dvsr});
        w_rem_nxt = w_ge ? (w_shift - {1'b0, w_dvsr}) : w_shift;
        w_quo_nxt = r_quo | ({31'd0, w_ge} << r_bit);
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.conv_req) w_state_nxt = S_DIV;
            S_DIV:   if (w_done)       w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        w_busy = (r_state == S_DIV);
    end

    // divider datapath, intermediate results and committed digits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_k     <= 3'd0;
            r_bit   <= 5'd31;
            r_dvd   <= 32'd0;
            r_quo   <= 32'd0;
            r_rem   <= 33'd0;
            r_min   <= 32'd0;
            r_sec   <= 32'd0;
            r_cs    <= 32'd0;
            r_mt    <= 4'd0;
            r_mo    <= 4'd0;
            r_st    <= 4'd0;
            r_so    <= 4'd0;
            r_o_mt  <= 4'd0;
            r_o_mo  <= 4'd0;
            r_o_st  <= 4'd0;
            r_o_so  <= 4'd0;
            r_o_ct  <= 4'd0;
            r_o_co  <= 4'd0;
            r_o_ovf <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (w_accept) begin
                r_dvd <= bus.count_in;
                r_k   <= 3'd0;
                r_bit <= 5'd31;
                r_rem <= 33'd0;
                r_quo <= 32'd0;
            end else if (r_state == S_DIV) begin
                if (r_bit != 5'd0) begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_bit <= r_bit - 5'd1;
                end else begin
                    // last bit: hand the result to the next division
                    r_rem <= 33'd0;
                    r_quo <= 32'd0;
                    r_bit <= 5'd31;
                    r_k   <= r_k + 3'd1;
                    case (r_k)
                        3'd0: r_dvd <= w_quo_nxt;
                        3'd1: begin
                            r_min <= w_quo_nxt;
                            r_dvd <= w_rem_nxt[31:0];
                        end
                        3'd2: begin
                            r_sec <= w_quo_nxt;
                            r_cs  <= w_rem_nxt[31:0];
                            r_dvd <= r_min;
                        end
                        3'd3: begin
                            // meaningless when minutes > 99; masked by saturation
                            r_mt  <= w_quo_nxt[3:0];
                            r_mo  <= w_rem_nxt[3:0];
                            r_dvd <= r_sec;
                        end
                        3'd4: begin
                            r_st  <= w_quo_nxt[3:0];
                            r_so  <= w_rem_nxt[3:0];
                            r_dvd <= r_cs;
                        end
                        default: begin
                            r_k     <= 3'd0;
                            r_valid <= 1'b1;
                            if (r_min > 32'd99) begin
                                r_o_mt  <= 4'd9;
                                r_o_mo  <= 4'd9;
                                r_o_st  <= 4'd5;
                                r_o_so  <= 4'd9;
                                r_o_ct  <= 4'd9;
                                r_o_co  <= 4'd9;
                                r_o_ovf <= 1'b1;
                            end else begin
                                r_o_mt  <= r_mt;
                                r_o_mo  <= r_mo;
                                r_o_st  <= r_st;
                                r_o_so  <= r_so;
                                r_o_ct  <= w_quo_nxt[3:0];
                                r_o_co  <= w_rem_nxt[3:0];
                                r_o_ovf <= 1'b0;
                            end
                        end
                    endcase
                end
            end
        end
    end

    assign bus.busy     = w_busy;
    assign bus.valid    = r_valid;
    assign bus.min_tens = r_o_mt;
    assign bus.min_ones = r_o_mo;
    assign bus.sec_tens = r_o_st;
    assign bus.sec_ones = r_o_so;
    assign bus.cs_tens  = r_o_ct;
    assign bus.cs_ones  = r_o_co;
    assign bus.overflow = r_o_ovf;
endmodule

// File: tb/tb_stopwatch_time_fmt.sv
// Directed bench for stopwatch_time_fmt with TICKS_PER_CS = 10.
module tb_stopwatch_time_fmt;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_bad_vb  = 0;
    int   n_bad_dig = 0;

    stopwatch_time_fmt_if bus();

    stopwatch_time_fmt #(.TICKS_PER_CS(32'd10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] cnt;
        logic [23:0] dig;
        logic        ovf;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [23:0] digits();
        return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones,
                bus.cs_tens, bus.cs_ones};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // invariants watched every cycle
    logic [23:0] prev_dig = 24'd0;
    always @(negedge clk) begin
        if (bus.valid && bus.busy) n_bad_vb++;
        if (digits() !== prev_dig && !bus.valid && !rst) n_bad_dig++;
        prev_dig = digits();
    end

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_digits", {8'd0, digits()}, 32'd0);
        chk("rst_flags", {29'd0, bus.busy, bus.valid, bus.overflow}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_conv(input string nm, input logic [31:0] cnt,
                            input logic [23:0] dig, input logic ovf);
        int n;
        bit got;
        @(negedge clk);
        bus.count_in = cnt;
        bus.conv_req = 1'b1;
        @(posedge clk);
        #1 bus.conv_req = 1'b0;
        chk({nm, "_busy"}, {31'd0, bus.busy}, 32'd1);
        n = 0; got = 0;
        while (n < 300 && !got) begin
            @(posedge clk); n++; #1;
            if (bus.valid) got = 1;
        end
        chk({nm, "_lat"}, n, 32'd192);
        chk({nm, "_dig"}, {8'd0, digits()}, {8'd0, dig});
        chk({nm, "_ovf"}, {31'd0, bus.overflow}, {31'd0, ovf});
        @(posedge clk); #1;
        chk({nm, "_vdrop"}, {31'd0, bus.valid}, 32'd0);
    endtask

    initial begin
        int n, nv, first;
        vecs[0] = '{"zero",    32'd0,       24'h000000, 1'b0};
        vecs[1] = '{"nominal", 32'd1234567, 24'h203456, 1'b0};
        vecs[2] = '{"max",     32'd5999999, 24'h995999, 1'b0};
        vecs[3] = '{"sat",     32'd6000000, 24'h995999, 1'b1};
        vecs[4] = '{"nine",    32'd9,       24'h000000, 1'b0};
        vecs[5] = '{"oneminp", 32'd60010,   24'h010001, 1'b0};

        bus.count_in = 32'd0;
        bus.conv_req = 1'b0;
        #12;
        chk("init_digits", {8'd0, digits()}, 32'd0);
        chk("init_flags", {29'd0, bus.busy, bus.valid, bus.overflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_conv(vecs[i].name, vecs[i].cnt, vecs[i].dig, vecs[i].ovf);

        // async reset with nonzero digits showing
        run_conv("pre_rst", 32'd1234567, 24'h203456, 1'b0);
        do_reset();

        // request during busy is ignored, count change after accept has no effect
        @(negedge clk);
        bus.count_in = 32'd1000;
        bus.conv_req = 1'b1;
        @(posedge clk);
        #1 bus.conv_req = 1'b0;
        n = 0; nv = 0; first = 0;
        while (n < 392) begin
            @(posedge clk); n++; #1;
            if (n == 50) begin bus.conv_req = 1'b1; bus.count_in = 32'd77777; end
            if (n == 51) bus.conv_req = 1'b0;
            if (bus.valid) begin
                nv++;
                if (first == 0) begin
                    first = n;
                    chk("busyreq_dig", {8'd0, digits()}, 32'h000100);
                end
            end
        end
        chk("busyreq_first", first, 32'd192);
        chk("busyreq_nvalid", nv, 32'd1);

        // reset in the middle of a conversion
        @(negedge clk);
        bus.count_in = 32'd1234567;
        bus.conv_req = 1'b1;
        @(posedge clk);
        #1 bus.conv_req = 1'b0;
        repeat (99) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        nv = 0;
        repeat (250) begin
            @(posedge clk); #1;
            if (bus.valid) nv++;
        end
        chk("midrst_nvalid", nv, 32'd0);
        chk("midrst_dig", {8'd0, digits()}, 32'd0);
        run_conv("after_rst", 32'd60010, 24'h010001, 1'b0);

        // conv_req held high: one result every 193 cycles
        @(negedge clk);
        bus.count_in = 32'd1234567;
        bus.conv_req = 1'b1;
        @(posedge clk);
        n = 0; nv = 0; first = 0;
        while (n < 400 && nv < 2) begin
            @(posedge clk); n++; #1;
            if (bus.valid) begin
                nv++;
                if (nv == 1) first = n;
            end
        end
        bus.conv_req = 1'b0;
        chk("held_first", first, 32'd192);
        chk("held_period", n - first, 32'd193);
        repeat (200) @(posedge clk);

        chk("valid_busy_overlap", n_bad_vb, 32'd0);
        chk("digit_glitch", n_bad_dig, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
